// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Consumes forwarded operands, stalls the pipeline while iterating and
// returns one XLEN-bit result on the single-cycle done pulse.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a one-cycle
// combinational product instead of the shift-add sequence.
//
// state | meaning
// IDLE  | waiting for start, operands captured on start
// CALC  | one multiplier / quotient bit per cycle
// DONE  | sign applied, result presented, done pulses
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              neg_main;
  logic              neg_rem;
  logic [XLEN-1:0]   result_q;

  logic              capture;
  logic              cap_div;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic              cap_short;
  logic              cap_neg_main;
  logic              cap_neg_rem;
  logic [XLEN-1:0]   cap_opnd;
  logic [2*XLEN-1:0] cap_acc;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic              div_qbit;
  logic [2*XLEN-1:0] acc_step;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fmt;

  assign capture = (state == S_IDLE) && start && !flush;

  // Operand decode at capture: magnitudes, signs and the divide special cases.
  // Special cases preload the final {remainder, quotient} with no sign fix-up.
  always_comb begin
    cap_div  = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && op_a[XLEN-1];
    b_neg    = b_signed && op_b[XLEN-1];
    a_mag    = a_neg ? (ZERO_X - op_a) : op_a;
    b_mag    = b_neg ? (ZERO_X - op_b) : op_b;
    div_zero = cap_div && (op_b == ZERO_X);
    div_ovf  = cap_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);
    cap_neg_main = a_neg ^ b_neg;
    cap_neg_rem  = a_neg;
    cap_short    = div_zero || div_ovf;
    if (cap_div) begin
      cap_opnd = b_mag;
      cap_acc  = {ZERO_X, a_mag};
    end else begin
      cap_opnd = a_mag;
      cap_acc  = {ZERO_X, b_mag};
    end
    if (div_zero) begin
      cap_acc      = {op_a, ALL_ONES};
      cap_neg_main = 1'b0;
      cap_neg_rem  = 1'b0;
    end else if (div_ovf) begin
      cap_acc      = {ZERO_X, MIN_NEG};
      cap_neg_main = 1'b0;
      cap_neg_rem  = 1'b0;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!cap_div) begin
      cap_acc   = {ZERO_X, a_mag} * {ZERO_X, b_mag};
      cap_short = 1'b1;
    end
`endif
  end

  // One iteration step: shift-add for multiply, restoring step for divide.
  // acc holds {partial/remainder, multiplier/dividend-then-quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opnd};
    div_qbit  = !div_diff[XLEN];
    if (op_q[2]) begin
      acc_step = {(div_qbit ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                  acc[XLEN-2:0], div_qbit};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and result select from the finished accumulator.
  always_comb begin
    prod = neg_main ? ({(2*XLEN){1'b0}} - acc) : acc;
    quot = neg_main ? (ZERO_X - acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_rem ? (ZERO_X - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fmt = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fmt = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fmt = quot;
      default:                fmt = rem;
    endcase
  end

  // Next-state logic; flush always wins and returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = cap_short ? S_DONE : S_CALC;
      S_CALC: if (cnt == CNT_LAST) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // State register and iteration counter (cleared whenever not iterating).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_CALC) cnt <= cnt + CW'(1);
      else                 cnt <= '0;
    end
  end

  // Operand capture in IDLE, accumulator iteration in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (capture) begin
      op_q     <= funct3;
      opnd     <= cap_opnd;
      acc      <= cap_acc;
      neg_main <= cap_neg_main;
      neg_rem  <= cap_neg_rem;
    end else if (state == S_CALC) begin
      acc <= acc_step;
    end
  end

  // Result holding register, loaded only on a delivered done.
  always_ff @(posedge clk) begin
    if (rst)       result_q <= '0;
    else if (done) result_q <= fmt;
  end

  // A flush or reset landing in DONE suppresses the pulse and keeps the old result.
  assign stall  = capture || (state == S_CALC);
  assign done   = (state == S_DONE) && !flush && !rst;
  assign result = done ? fmt : result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed stimulus against a plain
// arithmetic model of RV32M; one negedge process compares every cycle.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int plan_t0   = -100;
  int plan_end  = -100;
  int plan_done = -100;
  logic [31:0] plan_res = '0;
  logic [31:0] held_res = '0;
  bit          chk_en = 1'b0;
  bit          pinned = 1'b0;
  bit          lit_on = 1'b0;
  logic [31:0] lit_res = '0;
  int          lit_lat = 0;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "time limit");
  end

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return ONES;
        if (a == MINV && b == ONES) return MINV;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 32'h0) return ONES;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == MINV && b == ONES) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'h0 || (!f[0] && a == MINV && b == ONES))) return 1;
    if (!f[2] && FAST) return 1;
    return XLEN + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Single compare process: model-derived stall/done/result every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        es;
      logic        ed;
      logic [31:0] er;
      if (!pinned) begin
        pinned = 1'b1;
        chk("pin_div",    ref_op(3'b100, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        chk("pin_rem",    ref_op(3'b110, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        chk("pin_mulh",   ref_op(3'b001, MINV, MINV), 32'h4000_0000);
        chk("pin_mulhsu", ref_op(3'b010, ONES, ONES), 32'hFFFF_FFFF);
        chk("pin_mul",    ref_op(3'b000, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin_remu",   ref_op(3'b111, 32'd100, 32'd7), 32'd2);
        chk("pin_lat",    32'(ref_lat(3'b101, 32'd100, 32'd7)), 32'd33);
      end
      es = (cyc >= plan_t0) && (cyc <= plan_end);
      ed = (cyc == plan_done);
      er = ed ? plan_res : held_res;
      chk("stall",  32'(stall), 32'(es));
      chk("done",   32'(done),  32'(ed));
      chk("result", result, er);
      if (ed && lit_on) begin
        chk("lit_result",  result, lit_res);
        chk("lit_latency", 32'(cyc - plan_t0), 32'(lit_lat));
      end
      if (ed) held_res = plan_res;
      if (rst) held_res = '0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one op; abort_k >= 0 asserts flush (or rst) in cycle abort_k of the op.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int abort_k, input bit use_rst, input bit lit,
                       input logic [31:0] lit_val, input int lit_lat_in);
    int lat;
    lat = ref_lat(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    lit_on  = lit;
    lit_res = lit_val;
    lit_lat = lit_lat_in;
    plan_res = ref_op(f, a, b);
    plan_t0  = cyc;
    if (abort_k >= 0) begin
      plan_done = -100;
      if (abort_k == 0 && !use_rst) plan_end = cyc - 1;
      else plan_end = cyc + ((abort_k < lat) ? abort_k : lat - 1);
    end else begin
      plan_end  = cyc + lat - 1;
      plan_done = cyc + lat;
    end
    for (int k = 0; k <= lat; k++) begin
      if (k == abort_k) begin
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; rst = 1'b0;
      if (k == 0) begin
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
      if (k == abort_k) break;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    do_op(3'b100, 32'hFFFF_FFF9, 32'h2, -1, 1'b0, 1'b1, 32'hFFFF_FFFD, 33);
    do_op(3'b110, 32'hFFFF_FFF9, 32'h2, -1, 1'b0, 1'b1, 32'hFFFF_FFFF, 33);
    do_op(3'b101, 32'd5, 32'd0, -1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1);
    do_op(3'b111, 32'd5, 32'd0, -1, 1'b0, 1'b1, 32'h0000_0005, 1);
    do_op(3'b100, MINV, ONES, -1, 1'b0, 1'b1, MINV, 1);
    do_op(3'b110, MINV, ONES, -1, 1'b0, 1'b1, 32'h0, 1);
    do_op(3'b001, MINV, MINV, -1, 1'b0, 1'b1, 32'h4000_0000, FAST ? 1 : 33);
    do_op(3'b010, ONES, ONES, -1, 1'b0, 1'b1, 32'hFFFF_FFFF, FAST ? 1 : 33);

    do_op(3'b101, 32'h1234_5678, 32'd3, 10, 1'b0, 1'b0, 32'h0, 0);
    idle(1);
    do_op(3'b101, 32'd100, 32'd7, -1, 1'b0, 1'b1, 32'd14, 33);
    do_op(3'b101, 32'h1234_5678, 32'd3, 10, 1'b1, 1'b0, 32'h0, 0);
    idle(1);
    do_op(3'b101, 32'd100, 32'd7, -1, 1'b0, 1'b1, 32'd14, 33);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      int          r;
      int          ab;
      bit          ur;
      int          lat;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      r = int'($urandom_range(0, 15));
      if (r == 0) b = 32'h0;
      else if (r == 1) begin a = MINV; b = ONES; end
      else if (r == 2) b = 32'($urandom_range(1, 15));
      else if (r == 3) a = 32'($urandom_range(0, 100));
      else if (r == 4) b = ONES;
      lat = ref_lat(f, a, b);
      ab = -1;
      ur = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        ab = int'($urandom_range(0, lat));
        ur = 1'($urandom_range(0, 1));
      end
      do_op(f, a, b, ab, ur, 1'b0, 32'h0, 0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the forwarding control. It consumes the already-forwarded EX operands, stalls the pipeline while it iterates, and returns a single 32-bit result that EX/MEM latches on the `done` cycle. A sequencer with an iteration counter implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Iteration count equals `XLEN`.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: EX holds an M-extension instruction with valid forwarded operands.
- `flush`, input, 1: kill the current operation (branch or exception flush of EX).
- `funct3`, input, 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`, input, XLEN: rs1 value after forwarding.
- `op_b`, input, XLEN: rs2 value after forwarding.
- `stall`, output, 1: freeze PC, IF/ID, ID/EX and EX; insert a bubble into EX/MEM.
- `done`, output, 1: one-cycle pulse; `result` is valid this cycle.
- `result`, output, XLEN: operation result. Holds its value until the next `done`.

## Operation
- States:
  - IDLE: waiting for `start`.
  - CALC: iterating.
  - DONE: result valid, `done` pulses.
- Operand capture (IDLE, `start`=1):
  - Latch `funct3`.
  - Latch magnitudes of `op_a` and `op_b`. Signed operands are DIV/REM both, MULH both, MULHSU `op_a` only.
  - Latch the result sign.
  - Clear the counter, then go to CALC.
- Division special cases are decided at capture and skip CALC (IDLE→DONE):
  - `op_b`=0: quotient = all ones; remainder = `op_a`.
  - DIV/REM with `op_a`=0x80000000 and `op_b`=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- CALC, multiply: shift-add, one multiplier bit per cycle into a 2·XLEN accumulator.
- CALC, divide: restoring division, one quotient bit per cycle.
- After iteration `XLEN-1` (counter = XLEN-1), go to DONE.
- DONE:
  - Apply the sign: two's-complement negate when the latched sign is set. The remainder sign follows the dividend.
  - Select the result: MUL = low half; MULH* = high half; DIV* = quotient; REM* = remainder.
  - Register `result`, assert `done`, then go to IDLE unconditionally.
  - `start` is ignored in DONE.
- `stall` = (IDLE & `start` & ~`flush`) | CALC. It is combinational from state and `start`. It is 0 in DONE.
- `flush`: from any state, next state is IDLE. No `done` is produced; `result` is unchanged.
- `flush` has priority over `start` and over counter completion.

## Timing
- Reset: state IDLE, counter 0, `stall`=0, `done`=0, `result`=0.
- `rst` mid-operation aborts to IDLE with the same values and produces no `done`.
- Normal op, with `start` first seen in cycle 0:
  - Cycle 0: `stall` high (combinational).
  - Cycles 1..XLEN: CALC, `stall` high.
  - Cycle XLEN+1: DONE, `done`=1, `stall`=0. EX/MEM latches `result` at the end of this cycle.
  - Total: XLEN+1 stall cycles; result in cycle 33 for XLEN=32.
- Special-case divide: stall in cycle 0 only; DONE in cycle 1.
- Back-to-back M instructions: the next `start` is accepted in the cycle after DONE. There is no dead cycle beyond the DONE cycle.
- Operands are sampled only in the IDLE capture cycle. Later changes on `op_a`/`op_b` are ignored.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 2·XLEN combinational product computed at capture.
  - Path is IDLE→DONE: one stall cycle, `done` in cycle 1.
  - Division is unchanged.
- Not defined: all multiplies iterate like divides (XLEN+1 stall cycles).

## Test plan
- Reset: hold `rst` 2 cycles → `stall`=0, `done`=0, `result`=0x00000000.
- DIV −7 / 2:
  - Stimulus: `funct3`=100, `op_a`=0xFFFFFFF9, `op_b`=2.
  - Response: `stall` high cycles 0..32; `done` cycle 33; `result`=0xFFFFFFFD.
  - Repeat with REM (110) → 0xFFFFFFFF.
- Divide-by-zero:
  - DIVU 5/0 → `result`=0xFFFFFFFF in cycle 1.
  - REMU 5/0 → 0x00000005 in cycle 1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0x00000000; `done` in cycle 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000, with:
  - `done` in cycle 33 without the macro;
  - `done` in cycle 1 with `MULDIV_FAST_MUL_EN`.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Flush/reset mid-op:
  - Start DIVU, assert `flush` in cycle 10 → IDLE next cycle, no `done`, `result` unchanged.
  - New DIVU 100/7 started in cycle 12 → `result`=14 in cycle 45.
  - Same check with `rst` in place of `flush`.
